// File: rtl/lvds_tx_framer.sv
// rtl/lvds_tx_framer.sv - LVDS byte framer: training, start marker, then 4-byte MSB-first frames
module lvds_tx_framer #(
   parameter logic [7:0]  TRAIN_BYTE  = 8'h35,
   parameter logic [7:0]  MARKER_BYTE = 8'h77,
   parameter logic [7:0]  IDLE_BYTE   = 8'h52,
   parameter int unsigned MIN_TRAIN   = 16
) (
   input  logic        tx_inclock,
   input  logic        pll_areset,
   input  logic        tx_locked,
   input  logic        tx_align_done,
   input  logic [31:0] enq_tx,
   input  logic        RDY_enq_tx,
   output logic        EN_enq_tx,
   output logic [7:0]  tx_in,
   output logic        link_up,
   output logic [15:0] frame_count,
   output logic [2:0]  tx_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_TRAIN = 3'd1,
      S_MARK  = 3'd2,
      S_B0    = 3'd3,
      S_B1    = 3'd4,
      S_B2    = 3'd5,
      S_B3    = 3'd6
   } state_t;

   state_t      state;
   logic [23:0] hold;
   logic [15:0] train_cnt;
   logic        align_meta;
   logic        align_sync;

   assign tx_state  = state;
   assign link_up   = (state >= S_MARK) && (state <= S_B3);
   assign EN_enq_tx = ((state == S_MARK) || ((state == S_B3) && align_sync))
                      && RDY_enq_tx && tx_locked;

   always_ff @(posedge tx_inclock or posedge pll_areset) begin
      if (pll_areset) begin
         state       <= S_IDLE;
         tx_in       <= 8'h00;
         hold        <= {3{IDLE_BYTE}};
         train_cnt   <= 16'd0;
         frame_count <= 16'd0;
         align_meta  <= 1'b0;
         align_sync  <= 1'b0;
      end else begin
         align_meta <= tx_align_done;
         align_sync <= align_meta;
         if (EN_enq_tx)
            frame_count <= frame_count + 16'd1;

         if (!tx_locked) begin
            // losing lock abandons any partial frame; its word is not resent
            state <= S_IDLE;
            tx_in <= 8'h00;
         end else begin
            case (state)
               S_IDLE: begin
                  state     <= S_TRAIN;
                  tx_in     <= TRAIN_BYTE;
                  train_cnt <= 16'd0;
               end
               S_TRAIN: begin
                  if (train_cnt != 16'hFFFF)
                     train_cnt <= train_cnt + 16'd1;
                  if ((train_cnt >= 16'(MIN_TRAIN - 1)) && align_sync) begin
                     state <= S_MARK;
                     tx_in <= MARKER_BYTE;
                  end else begin
                     tx_in <= TRAIN_BYTE;
                  end
               end
               S_B0: begin
                  state <= S_B1;
                  tx_in <= hold[23:16];
               end
               S_B1: begin
                  state <= S_B2;
                  tx_in <= hold[15:8];
               end
               S_B2: begin
                  state <= S_B3;
                  tx_in <= hold[7:0];
               end
               S_MARK, S_B3: begin
                  if ((state == S_B3) && !align_sync) begin
                     state     <= S_TRAIN;
                     tx_in     <= TRAIN_BYTE;
                     train_cnt <= 16'd0;
                  end else begin
                     // frame start: real word if dequeued, otherwise an idle frame
                     state <= S_B0;
                     if (EN_enq_tx) begin
                        tx_in <= enq_tx[31:24];
                        hold  <= enq_tx[23:0];
                     end else begin
                        tx_in <= IDLE_BYTE;
                        hold  <= {3{IDLE_BYTE}};
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
                  tx_in <= 8'h00;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// tb/tb_lvds_tx_framer.sv - directed self-checking bench for lvds_tx_framer
module tb_lvds_tx_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_locked;
   logic        tx_align_done;
   logic [31:0] enq_tx;
   logic        RDY_enq_tx;
   logic        EN_enq_tx;
   logic [7:0]  tx_in;
   logic        link_up;
   logic [15:0] frame_count;
   logic [2:0]  tx_state;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_fc = 16'd0;

   always #5 clk = ~clk;

   lvds_tx_framer dut (
      .tx_inclock    (clk),
      .pll_areset    (rst),
      .tx_locked     (tx_locked),
      .tx_align_done (tx_align_done),
      .enq_tx        (enq_tx),
      .RDY_enq_tx    (RDY_enq_tx),
      .EN_enq_tx     (EN_enq_tx),
      .tx_in         (tx_in),
      .link_up       (link_up),
      .frame_count   (frame_count),
      .tx_state      (tx_state)
   );

   task automatic wait_state(input logic [2:0] s, input int limit, input string name);
      int n = 0;
      while (tx_state !== s && n < limit) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (tx_state !== s) begin
         bad++;
         $display("FAIL %s: state=%0d required=%0d after %0d cycles", name, tx_state, s, n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; tx_locked = 1'b1; tx_align_done = 1'b0; RDY_enq_tx = 1'b1; enq_tx = 32'h8000_0000;
      repeat (3) @(negedge clk);
      total++; if (tx_state !== 3'd0) begin bad++; $display("FAIL reset_state: got=%0d exp=0", tx_state); end
      total++; if (tx_in !== 8'h00) begin bad++; $display("FAIL reset_tx_in: got=%h exp=00", tx_in); end
      total++; if (link_up !== 1'b0) begin bad++; $display("FAIL reset_link_up: got=%b exp=0", link_up); end
      total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL reset_en: got=%b exp=0", EN_enq_tx); end
      total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL reset_fc: got=%h exp=0000", frame_count); end
   endtask

   task automatic test_bringup;
      int n = 0;
      RDY_enq_tx = 1'b0; tx_align_done = 1'b1; rst = 1'b0;
      @(negedge clk);
      while (tx_state === 3'd1 && n < 100) begin
         total++; if (tx_in !== 8'h35) begin bad++; $display("FAIL train_byte: got=%h exp=35", tx_in); end
         n++;
         @(negedge clk);
      end
      total++; if (n != 16) begin bad++; $display("FAIL train_len: got=%0d exp=16", n); end
      total++; if (tx_state !== 3'd2) begin bad++; $display("FAIL mark_state: got=%0d exp=2", tx_state); end
      total++; if (tx_in !== 8'h77) begin bad++; $display("FAIL mark_byte: got=%h exp=77", tx_in); end
      total++; if (link_up !== 1'b1) begin bad++; $display("FAIL mark_link_up: got=%b exp=1", link_up); end
   endtask

   task automatic test_data;
      logic [7:0] exp_bytes [4] = '{8'h81, 8'h23, 8'hAB, 8'hCD};
      RDY_enq_tx = 1'b1; enq_tx = 32'h8123_ABCD;
      #1;
      total++; if (EN_enq_tx !== 1'b1) begin bad++; $display("FAIL data_en_mark: got=%b exp=1", EN_enq_tx); end
      exp_fc++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         RDY_enq_tx = 1'b0;
         #1;
         total++; if (tx_in !== exp_bytes[i]) begin bad++; $display("FAIL data_byte%0d: got=%h exp=%h", i, tx_in, exp_bytes[i]); end
         total++; if (tx_state !== 3'(3 + i)) begin bad++; $display("FAIL data_state%0d: got=%0d exp=%0d", i, tx_state, 3 + i); end
         total++; if (link_up !== 1'b1) begin bad++; $display("FAIL data_link_up%0d: got=%b exp=1", i, link_up); end
         total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL data_en%0d: got=%b exp=0", i, EN_enq_tx); end
      end
      total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL data_fc: got=%h exp=%h", frame_count, exp_fc); end
   endtask

   task automatic test_empty;
      RDY_enq_tx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++; if (tx_in !== 8'h52) begin bad++; $display("FAIL empty_byte%0d: got=%h exp=52", i, tx_in); end
         total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL empty_en%0d: got=%b exp=0", i, EN_enq_tx); end
         total++; if (tx_state !== 3'(3 + (i % 4))) begin bad++; $display("FAIL empty_state%0d: got=%0d exp=%0d", i, tx_state, 3 + (i % 4)); end
      end
      total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL empty_fc: got=%h exp=%h", frame_count, exp_fc); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] words [3] = '{32'hDEAD_BEEF, 32'h0102_0304, 32'hF00D_CAFE};
      logic [31:0] w;
      for (int k = 0; k < 3; k++) begin
         w = words[k];
         enq_tx = w; RDY_enq_tx = 1'b1;
         #1;
         total++; if (EN_enq_tx !== 1'b1) begin bad++; $display("FAIL b2b_en_start%0d: got=%b exp=1", k, EN_enq_tx); end
         exp_fc++;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            RDY_enq_tx = (k < 2) || (i < 3);
            if (k == 2 && i == 3) RDY_enq_tx = 1'b0;
            #1;
            total++; if (tx_in !== w[31 - 8*i -: 8]) begin bad++; $display("FAIL b2b_byte%0d_%0d: got=%h exp=%h", k, i, tx_in, w[31 - 8*i -: 8]); end
            if (i < 3) begin
               total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL b2b_en_mid%0d_%0d: got=%b exp=0", k, i, EN_enq_tx); end
            end
         end
      end
      total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL b2b_fc: got=%h exp=%h", frame_count, exp_fc); end
   endtask

   task automatic test_align_fault;
      RDY_enq_tx = 1'b0;
      wait_state(3'd4, 10, "align_reach_b1");
      tx_align_done = 1'b0;
      @(negedge clk);
      total++; if (tx_in !== 8'h52) begin bad++; $display("FAIL align_b2_byte: got=%h exp=52", tx_in); end
      @(negedge clk);
      total++; if (tx_state !== 3'd6) begin bad++; $display("FAIL align_b3_state: got=%0d exp=6", tx_state); end
      RDY_enq_tx = 1'b1;
      #1;
      total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL align_b3_en: got=%b exp=0", EN_enq_tx); end
      @(negedge clk);
      RDY_enq_tx = 1'b0;
      total++; if (tx_state !== 3'd1) begin bad++; $display("FAIL align_retrain_state: got=%0d exp=1", tx_state); end
      total++; if (tx_in !== 8'h35) begin bad++; $display("FAIL align_retrain_byte: got=%h exp=35", tx_in); end
      total++; if (link_up !== 1'b0) begin bad++; $display("FAIL align_retrain_link: got=%b exp=0", link_up); end
      repeat (20) @(negedge clk);
      total++; if (tx_state !== 3'd1) begin bad++; $display("FAIL align_hold_train: got=%0d exp=1", tx_state); end
      total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL align_fc: got=%h exp=%h", frame_count, exp_fc); end
      tx_align_done = 1'b1;
      wait_state(3'd2, 40, "align_recover_mark");
   endtask

   task automatic test_lock_fault;
      wait_state(3'd5, 10, "lock_reach_b2");
      RDY_enq_tx = 1'b1; tx_locked = 1'b0;
      #1;
      total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL lock_en_b2: got=%b exp=0", EN_enq_tx); end
      @(negedge clk);
      total++; if (tx_state !== 3'd0) begin bad++; $display("FAIL lock_idle_state: got=%0d exp=0", tx_state); end
      total++; if (tx_in !== 8'h00) begin bad++; $display("FAIL lock_idle_byte: got=%h exp=00", tx_in); end
      total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL lock_idle_en: got=%b exp=0", EN_enq_tx); end
      total++; if (frame_count !== exp_fc) begin bad++; $display("FAIL lock_fc: got=%h exp=%h", frame_count, exp_fc); end
      RDY_enq_tx = 1'b0; tx_locked = 1'b1;
      @(negedge clk);
      total++; if (tx_state !== 3'd1) begin bad++; $display("FAIL lock_relock_state: got=%0d exp=1", tx_state); end
      wait_state(3'd2, 40, "lock_recover_mark");
   endtask

   task automatic test_wrap;
      RDY_enq_tx = 1'b0;
      @(negedge clk);
      force dut.frame_count = 16'hFFFF;
      #1;
      release dut.frame_count;
      wait_state(3'd6, 10, "wrap_reach_b3");
      enq_tx = 32'h8000_0001; RDY_enq_tx = 1'b1;
      #1;
      total++; if (EN_enq_tx !== 1'b1) begin bad++; $display("FAIL wrap_en: got=%b exp=1", EN_enq_tx); end
      @(negedge clk);
      RDY_enq_tx = 1'b0;
      total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_fc: got=%h exp=0000", frame_count); end
      total++; if (tx_in !== 8'h80) begin bad++; $display("FAIL wrap_byte: got=%h exp=80", tx_in); end
   endtask

   task automatic test_reset_midframe;
      wait_state(3'd4, 10, "rst_reach_b1");
      RDY_enq_tx = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      total++; if (tx_state !== 3'd0) begin bad++; $display("FAIL rstmid_state: got=%0d exp=0", tx_state); end
      total++; if (tx_in !== 8'h00) begin bad++; $display("FAIL rstmid_tx_in: got=%h exp=00", tx_in); end
      total++; if (link_up !== 1'b0) begin bad++; $display("FAIL rstmid_link: got=%b exp=0", link_up); end
      total++; if (EN_enq_tx !== 1'b0) begin bad++; $display("FAIL rstmid_en: got=%b exp=0", EN_enq_tx); end
      total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL rstmid_fc: got=%h exp=0000", frame_count); end
      @(negedge clk);
      RDY_enq_tx = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      total++; if (tx_state !== 3'd1) begin bad++; $display("FAIL rstmid_train: got=%0d exp=1", tx_state); end
      total++; if (tx_in !== 8'h35) begin bad++; $display("FAIL rstmid_train_byte: got=%h exp=35", tx_in); end
   endtask

   initial begin
      test_reset;
      test_bringup;
      test_data;
      test_empty;
      test_back_to_back;
      test_align_fault;
      test_lock_fault;
      test_wrap;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
